// File: rtl/aid_pkg.sv
// Shared types and constants for the aid request queues, final selector and serve logic.
package aid_pkg;
    localparam int PRIO_W        = 2;
    localparam int ZONE_W        = 8;
    localparam int BOOST_AGE_DEF = 16;

    typedef struct packed {
        logic [PRIO_W-1:0] prio;
        logic [ZONE_W-1:0] zone;
    } aid_req_t;
endpackage

// File: rtl/aid_fifo_mem.sv
// DEPTH x aid_req_t register array with one write port and a combinational read port.
module aid_fifo_mem
    import aid_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_addr,
    input  aid_req_t         wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output aid_req_t         rd_data
);
    // No reset: contents are only observed through the count-qualified head.
    aid_req_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/aid_request_queue.sv
// Strict-FIFO request buffer for one aid class; ages the head entry and flags Boost.
module aid_request_queue
    import aid_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BOOST_AGE = BOOST_AGE_DEF,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req_Valid,
    input  logic [PRIO_W-1:0] Req_Priority,
    input  logic [ZONE_W-1:0] Req_Zone,
    output logic              Req_Ready,
    input  logic              Serve,
    output logic              Head_Valid,
    output logic              Head_Boost,
    output logic [PRIO_W-1:0] Head_Priority,
    output logic [ZONE_W-1:0] Head_Zone,
    output logic [PTR_W:0]    Count,
    output logic              Overflow
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [7:0]     AGE_MAX = 8'(BOOST_AGE);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [7:0]       age;
    logic             overflow;
    logic             head_valid, full, pop, push;
    aid_req_t         wr_data, rd_data;

    assign head_valid = (count != '0);
    assign full       = (count == DEPTH_C);
    assign pop        = Serve && head_valid;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign Req_Ready  = !full || pop;
    assign push       = Req_Valid && Req_Ready;
    assign wr_data    = '{prio: Req_Priority, zone: Req_Zone};

    aid_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            age      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (Req_Valid && !Req_Ready) overflow <= 1'b1;
            // Empty, popped, or first push into empty all restart the head's wait.
            if (!head_valid || pop) age <= '0;
            else if (age != AGE_MAX) age <= age + 8'd1;
        end
    end

    assign Head_Valid    = head_valid;
    assign Head_Boost    = head_valid && (age == AGE_MAX);
    assign Head_Priority = head_valid ? rd_data.prio : '0;
    assign Head_Zone     = head_valid ? rd_data.zone : '0;
    assign Count         = count;
    assign Overflow      = overflow;
endmodule

// File: tb/tb_aid_request_queue.sv
// Directed bench for aid_request_queue: FIFO order, full/overflow, boost aging, async reset.
module tb_aid_request_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       Req_Valid, Req_Ready, Serve;
    logic [1:0] Req_Priority, Head_Priority;
    logic [7:0] Req_Zone, Head_Zone;
    logic       Head_Valid, Head_Boost, Overflow;
    logic [3:0] Count;

    int n_chk = 0;
    int n_err = 0;

    aid_request_queue #(.DEPTH(8), .BOOST_AGE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .Req_Valid     (Req_Valid),
        .Req_Priority  (Req_Priority),
        .Req_Zone      (Req_Zone),
        .Req_Ready     (Req_Ready),
        .Serve         (Serve),
        .Head_Valid    (Head_Valid),
        .Head_Boost    (Head_Boost),
        .Head_Priority (Head_Priority),
        .Head_Zone     (Head_Zone),
        .Count         (Count),
        .Overflow      (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] p, input logic [7:0] z);
        Req_Valid = 1'b1; Req_Priority = p; Req_Zone = z;
        step();
        Req_Valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(Head_Valid), 0);
        chk({tag, "_boost"}, 32'(Head_Boost), 0);
        chk({tag, "_prio"},  32'(Head_Priority), 0);
        chk({tag, "_zone"},  32'(Head_Zone), 0);
        chk({tag, "_ready"}, 32'(Req_Ready), 1);
        chk({tag, "_count"}, 32'(Count), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; Req_Valid = 1'b0; Serve = 1'b0; Req_Priority = '0; Req_Zone = '0;
        #12;
        check_reset_outputs("rst");
        chk("rst_ovf", 32'(Overflow), 0);
        step();
        rst = 1'b0;
        step();

        // FIFO order
        push(2'd2, 8'h11);
        chk("t1_valid", 32'(Head_Valid), 1);
        chk("t1_zone",  32'(Head_Zone), 32'h11);
        chk("t1_prio",  32'(Head_Priority), 2);
        push(2'd1, 8'h22);
        push(2'd3, 8'h33);
        chk("t1_count", 32'(Count), 3);
        chk("t1_head_still", 32'(Head_Zone), 32'h11);
        Serve = 1'b1;
        step();
        chk("t1_pop1", 32'(Head_Zone), 32'h22);
        chk("t1_pop1_prio", 32'(Head_Priority), 1);
        step();
        chk("t1_pop2", 32'(Head_Zone), 32'h33);
        step();
        Serve = 1'b0;
        chk("t1_empty_valid", 32'(Head_Valid), 0);
        chk("t1_empty_zone",  32'(Head_Zone), 0);
        chk("t1_empty_prio",  32'(Head_Priority), 0);
        chk("t1_empty_count", 32'(Count), 0);

        // Full queue drops a 9th request and sets Overflow
        for (int i = 0; i < 8; i++) push(2'd0, 8'(8'h40 + i));
        chk("t2_count", 32'(Count), 8);
        chk("t2_ready_full", 32'(Req_Ready), 0);
        Req_Valid = 1'b1; Req_Zone = 8'h99;
        #1;
        chk("t2_ready_offer", 32'(Req_Ready), 0);
        step();
        Req_Valid = 1'b0;
        chk("t2_ovf", 32'(Overflow), 1);
        chk("t2_count_after", 32'(Count), 8);
        Serve = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_drain%0d", i), 32'(Head_Zone), 32'h40 + i);
            step();
        end
        Serve = 1'b0;
        chk("t2_drained", 32'(Head_Valid), 0);
        chk("t2_ovf_sticky", 32'(Overflow), 1);

        do_reset();
        chk("t3_ovf_cleared", 32'(Overflow), 0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(2'd1, 8'(8'h50 + i));
        Req_Valid = 1'b1; Req_Zone = 8'hAA; Serve = 1'b1;
        #1;
        chk("t3_ready", 32'(Req_Ready), 1);
        chk("t3_head0", 32'(Head_Zone), 32'h50);
        step();
        Req_Valid = 1'b0;
        chk("t3_count", 32'(Count), 8);
        chk("t3_ovf", 32'(Overflow), 0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("t3_serve%0d", i), 32'(Head_Zone), 32'h50 + i);
            step();
        end
        chk("t3_serve_aa", 32'(Head_Zone), 32'hAA);
        step();
        Serve = 1'b0;
        chk("t3_empty", 32'(Count), 0);

        // Boost aging
        push(2'd3, 8'h61);
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("t4_boost_c%0d", c), 32'(Head_Boost), (c >= 17) ? 1 : 0);
            if (c == 1) begin
                Req_Valid = 1'b1; Req_Zone = 8'h62;
            end else begin
                Req_Valid = 1'b0;
            end
            step();
        end
        chk("t4_boost_hold", 32'(Head_Boost), 1);
        chk("t4_head_zone", 32'(Head_Zone), 32'h61);
        Serve = 1'b1;
        step();
        Serve = 1'b0;
        chk("t4_next_zone", 32'(Head_Zone), 32'h62);
        chk("t4_next_boost", 32'(Head_Boost), 0);
        chk("t4_count", 32'(Count), 1);
        Serve = 1'b1;
        step();
        Serve = 1'b0;

        // Serve on an empty queue
        Serve = 1'b1;
        step();
        step();
        Serve = 1'b0;
        chk("t5_count", 32'(Count), 0);
        chk("t5_valid", 32'(Head_Valid), 0);
        chk("t5_zone",  32'(Head_Zone), 0);
        chk("t5_ready", 32'(Req_Ready), 1);
        push(2'd2, 8'h71);
        chk("t5_push_zone", 32'(Head_Zone), 32'h71);
        chk("t5_push_count", 32'(Count), 1);
        Serve = 1'b1;
        step();
        Serve = 1'b0;

        // Async reset mid-cycle with 5 entries and head age 10
        for (int i = 0; i < 5; i++) push(2'd1, 8'(8'h81 + i));
        for (int i = 0; i < 6; i++) step();
        chk("t6_count_pre", 32'(Count), 5);
        chk("t6_boost_pre", 32'(Head_Boost), 0);
        chk("t6_zone_pre",  32'(Head_Zone), 32'h81);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("t6_count_post", 32'(Count), 0);
        chk("t6_ovf_post", 32'(Overflow), 0);
        chk("t6_valid_post", 32'(Head_Valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
